// File: rtl/spim_slave_regs.sv
// -----------------------------------------------------------------------------
// spim_slave_regs
//   SPI slave (mode 0, MSB first) that exposes a byte-wide register file to an
//   HPS SPI master routed into the fabric. All logic runs on clk_clk. The SPI
//   pins are oversampled through 2-FF synchronizers, so clk_clk must be at
//   least 8x the SCLK frequency.
//
//   Frame: 16 bits, b15 = R/nW, b14:8 = address, b7:0 = write data.
//     addr < NUM_REGS : read/write register
//     addr 0x7E       : read status_in (writes dropped)
//     addr 0x7F       : read ID_VALUE  (writes dropped)
//     anything else   : reads 0x00, writes dropped
//
// Ports
//   clk_clk      in   system clock
//   reset_reset  in   synchronous, active-high reset
//   spi_sclk     in   SPI clock (async)
//   spi_mosi     in   master-out data (async)
//   spi_ss_n     in   active-low slave select (async)
//   spi_miso     out  slave-out data
//   spi_miso_oe  out  1 = drive MISO
//   status_in    in   value read back at address 0x7E
//   reg_out      out  register file, register k at [8k+7:8k]
//   wr_strobe    out  1-cycle pulse per committed register write
//   wr_addr      out  address of the last committed write (held)
//   frame_err    out  1-cycle pulse when a frame aborts after 1..15 bits
// -----------------------------------------------------------------------------
module spim_slave_regs #(
  parameter int          NUM_REGS = 8,
  parameter logic [7:0]  ID_VALUE = 8'hA5
) (
  input  logic                  clk_clk,
  input  logic                  reset_reset,
  input  logic                  spi_sclk,
  input  logic                  spi_mosi,
  input  logic                  spi_ss_n,
  output logic                  spi_miso,
  output logic                  spi_miso_oe,
  input  logic [7:0]            status_in,
  output logic [8*NUM_REGS-1:0] reg_out,
  output logic                  wr_strobe,
  output logic [6:0]            wr_addr,
  output logic                  frame_err
);

  typedef enum logic [2:0] {WAIT_IDLE, IDLE, CMD, DATA, DONE} state_e;

  // Synchronizers. Stage [2] of sclk and ss_n is the edge-detect history.
  logic [2:0] sclk_sync_q;
  logic [1:0] mosi_sync_q;
  logic [2:0] ss_sync_q;

  logic sclk_rise, sclk_fall, ss_rise, ss_fall, ss_n_s, mosi_s;

  state_e                    state_q, state_d;
  logic [3:0]                cnt_q, cnt_d;       // SCLK rises seen in this frame
  logic [6:0]                sh_q, sh_d;         // previously received bits
  logic [7:0]                cmd_q, cmd_d;       // latched command byte
  logic [7:0]                tx_q, tx_d;
  logic                      miso_q, miso_d;
  logic [NUM_REGS-1:0][7:0]  regs_q, regs_d;
  logic                      wr_strobe_q, wr_strobe_d;
  logic [6:0]                wr_addr_q, wr_addr_d;
  logic                      frame_err_q, frame_err_d;

  logic [7:0] rx_byte;
  logic [7:0] rd_val;

  // ss_n resets to "selected" so that a frame in flight across reset is not
  // mistaken for an idle bus; WAIT_IDLE only leaves once ss_n is seen high.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      ss_sync_q   <= '0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[1:0], spi_sclk};
      mosi_sync_q <= {mosi_sync_q[0], spi_mosi};
      ss_sync_q   <= {ss_sync_q[1:0], spi_ss_n};
    end
  end

  assign sclk_rise =  sclk_sync_q[1] & ~sclk_sync_q[2];
  assign sclk_fall = ~sclk_sync_q[1] &  sclk_sync_q[2];
  assign ss_rise   =  ss_sync_q[1]   & ~ss_sync_q[2];
  assign ss_fall   = ~ss_sync_q[1]   &  ss_sync_q[2];
  assign ss_n_s    =  ss_sync_q[1];
  assign mosi_s    =  mosi_sync_q[1];

  // Byte completed by the current rise (valid on the 8th and 16th rise).
  assign rx_byte = {sh_q, mosi_s};

  // Read-back mux, addressed by the command byte being completed.
  always_comb begin
    rd_val = 8'h00;
    if (rx_byte[6:0] == 7'h7E) begin
      rd_val = status_in;
    end else if (rx_byte[6:0] == 7'h7F) begin
      rd_val = ID_VALUE;
    end else begin
      for (int k = 0; k < NUM_REGS; k++) begin
        if (rx_byte[6:0] == 7'(k)) rd_val = regs_q[k];
      end
    end
  end

  // NOTE: every signal written here gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sh_d        = sh_q;
    cmd_d       = cmd_q;
    tx_d        = tx_q;
    miso_d      = miso_q;
    regs_d      = regs_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    frame_err_d = 1'b0;

    unique case (state_q)
      WAIT_IDLE: begin
        miso_d = 1'b0;
        if (ss_n_s) state_d = IDLE;
      end

      IDLE: begin
        miso_d = 1'b0;
        if (ss_fall) begin
          state_d = CMD;
          cnt_d   = '0;
        end
      end

      CMD: begin
        if (ss_rise) begin
          state_d     = IDLE;
          frame_err_d = (cnt_q != 4'd0) || sclk_rise;
        end else if (sclk_rise) begin
          sh_d  = rx_byte[6:0];
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd7) begin
            cmd_d   = rx_byte;
            // Write frames shift out zeros.
            tx_d    = rx_byte[7] ? rd_val : 8'h00;
            state_d = DATA;
          end
        end
      end

      DATA: begin
        // The 16th rise wins over a simultaneous ss_n rise.
        if (sclk_rise && cnt_q == 4'd15) begin
          miso_d  = 1'b0;
          state_d = ss_rise ? IDLE : DONE;
          if (!cmd_q[7]) begin
            for (int k = 0; k < NUM_REGS; k++) begin
              if (cmd_q[6:0] == 7'(k)) begin
                regs_d[k]   = rx_byte;
                wr_strobe_d = 1'b1;
                wr_addr_d   = cmd_q[6:0];
              end
            end
          end
        end else if (ss_rise) begin
          miso_d      = 1'b0;
          state_d     = IDLE;
          frame_err_d = 1'b1;
        end else begin
          if (sclk_rise) begin
            sh_d  = rx_byte[6:0];
            cnt_d = cnt_q + 4'd1;
          end
          if (sclk_fall) begin
            miso_d = tx_q[7];
            tx_d   = {tx_q[6:0], 1'b0};
          end
        end
      end

      DONE: begin
        miso_d = 1'b0;
        if (ss_rise) state_d = IDLE;
      end

      default: state_d = WAIT_IDLE;
    endcase
  end

  // NOTE: state updates use non-blocking assignments so every register sees
  // the pre-edge values of the others. The register file is reset as a whole
  // because its contents drive fabric outputs that must come up at zero.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state_q     <= WAIT_IDLE;
      cnt_q       <= '0;
      sh_q        <= '0;
      cmd_q       <= '0;
      tx_q        <= '0;
      miso_q      <= 1'b0;
      regs_q      <= '0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sh_q        <= sh_d;
      cmd_q       <= cmd_d;
      tx_q        <= tx_d;
      miso_q      <= miso_d;
      regs_q      <= regs_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign spi_miso    = miso_q;
  assign spi_miso_oe = (state_q != WAIT_IDLE) && !ss_n_s;
  assign reg_out     = regs_q;
  assign wr_strobe   = wr_strobe_q;
  assign wr_addr     = wr_addr_q;
  assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_spim_slave_regs.sv
// -----------------------------------------------------------------------------
// tb_spim_slave_regs
//   Bench for spim_slave_regs. Drives SPI mode-0 frames at SCLK = clk/8 and
//   compares MISO, the register file, wr_strobe/frame_err pulse counts and
//   wr_addr against a byte-array model of the register map.
// -----------------------------------------------------------------------------
module tb_spim_slave_regs;

  localparam int         NUM_REGS = 8;
  localparam logic [7:0] ID_VALUE = 8'hA5;

  logic                  clk_clk = 1'b0;
  logic                  reset_reset;
  logic                  spi_sclk;
  logic                  spi_mosi;
  logic                  spi_ss_n;
  logic                  spi_miso;
  logic                  spi_miso_oe;
  logic [7:0]            status_in;
  logic [8*NUM_REGS-1:0] reg_out;
  logic                  wr_strobe;
  logic [6:0]            wr_addr;
  logic                  frame_err;

  spim_slave_regs #(.NUM_REGS(NUM_REGS), .ID_VALUE(ID_VALUE)) dut (
    .clk_clk     (clk_clk),
    .reset_reset (reset_reset),
    .spi_sclk    (spi_sclk),
    .spi_mosi    (spi_mosi),
    .spi_ss_n    (spi_ss_n),
    .spi_miso    (spi_miso),
    .spi_miso_oe (spi_miso_oe),
    .status_in   (status_in),
    .reg_out     (reg_out),
    .wr_strobe   (wr_strobe),
    .wr_addr     (wr_addr),
    .frame_err   (frame_err)
  );

  always #5 clk_clk = ~clk_clk;

  int total = 0;
  int bad   = 0;

  // Pulse counters: a 1-cycle pulse adds exactly 1.
  int strobe_cnt = 0;
  int err_cnt    = 0;
  always @(negedge clk_clk) begin
    if (wr_strobe) strobe_cnt++;
    if (frame_err) err_cnt++;
  end

  // Reference model of the register map.
  logic [7:0] mregs [NUM_REGS];
  logic [6:0] m_wr_addr;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk_clk);
  endtask

  function automatic logic [7:0] model_read(input logic [6:0] addr);
    if (addr == 7'h7E) return status_in;
    if (addr == 7'h7F) return ID_VALUE;
    if (int'(addr) < NUM_REGS) return mregs[int'(addr)];
    return 8'h00;
  endfunction

  function automatic logic [63:0] model_pack();
    logic [63:0] p = '0;
    for (int k = 0; k < NUM_REGS; k++) p[8*k +: 8] = mregs[k];
    return p;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NUM_REGS; k++) mregs[k] = 8'h00;
    m_wr_addr = 7'd0;
  endtask

  // Clocks out nbits of frame (MSB-aligned at bit 23); samples MISO just
  // before each rising SCLK. With simul_end, ss_n rises together with the
  // last SCLK rise.
  task automatic shift_bits(input int nbits, input logic [23:0] frame,
                            input bit simul_end, output logic [23:0] got_miso);
    got_miso = '0;
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = frame[23-i];
      wait_clks(4);
      got_miso[23-i] = spi_miso;
      if (simul_end && i == nbits - 1) spi_ss_n = 1'b1;
      spi_sclk = 1'b1;
      wait_clks(4);
      spi_sclk = 1'b0;
    end
  endtask

  task automatic run_frame(input string tag, input int nbits, input logic [23:0] frame,
                           input bit simul_end);
    logic [23:0] got_miso, exp_miso;
    logic        rw;
    logic [6:0]  addr;
    logic [7:0]  data, rv;
    int          s0, e0, exp_s, exp_e;
    rw   = frame[23];
    addr = frame[22:16];
    data = frame[15:8];
    rv   = model_read(addr);
    s0   = strobe_cnt;
    e0   = err_cnt;

    // Data-phase bits 8..15 carry the read value for read frames; all else 0.
    exp_miso = '0;
    for (int i = 0; i < nbits; i++)
      if (rw && i >= 8 && i < 16) exp_miso[23-i] = rv[15-i];

    spi_ss_n = 1'b0;
    wait_clks(4);
    check({tag, "_oe"}, 64'(spi_miso_oe), 64'd1);
    shift_bits(nbits, frame, simul_end, got_miso);
    if (!simul_end) begin
      wait_clks(4);
      spi_ss_n = 1'b1;
    end
    wait_clks(10);
    #1;

    exp_s = 0;
    exp_e = (nbits >= 1 && nbits < 16) ? 1 : 0;
    if (nbits >= 16 && !rw && int'(addr) < NUM_REGS) begin
      mregs[int'(addr)] = data;
      m_wr_addr         = addr;
      exp_s             = 1;
    end

    check({tag, "_miso"},    64'(got_miso),         64'(exp_miso));
    check({tag, "_regs"},    reg_out,               model_pack());
    check({tag, "_strobe"},  64'(strobe_cnt - s0),  64'(exp_s));
    check({tag, "_ferr"},    64'(err_cnt - e0),     64'(exp_e));
    check({tag, "_wraddr"},  64'(wr_addr),          64'(m_wr_addr));
    check({tag, "_idle"},    64'({spi_miso, spi_miso_oe}), 64'd0);
  endtask

  initial begin
    logic [23:0] dummy;
    int          s0, e0;

    reset_reset = 1'b1;
    spi_sclk    = 1'b0;
    spi_mosi    = 1'b0;
    spi_ss_n    = 1'b1;
    status_in   = 8'h00;
    model_reset();
    wait_clks(5);
    reset_reset = 1'b0;
    wait_clks(5);
    #1;
    check("rst_regs",   reg_out, 64'd0);
    check("rst_outs",   64'({spi_miso, spi_miso_oe, wr_strobe, frame_err}), 64'd0);
    check("rst_wraddr", 64'(wr_addr), 64'd0);

    // Basic write, then reads of register, ID and status.
    run_frame("wr03",  16, {16'h035A, 8'h00}, 0);
    run_frame("wr01",  16, {16'h01C3, 8'h00}, 0);
    run_frame("rd01",  16, {16'h8100, 8'h00}, 0);
    run_frame("rd7f",  16, {16'hFF00, 8'h00}, 0);
    status_in = 8'h3C;
    run_frame("rd7e",  16, {16'hFE00, 8'h00}, 0);

    // Dropped writes and out-of-range read.
    run_frame("wr7f",  16, {16'h7F11, 8'h00}, 0);
    run_frame("wr10",  16, {16'h1022, 8'h00}, 0);
    run_frame("rd10",  16, {16'h9000, 8'h00}, 0);

    // Aborted frame, then a clean one.
    run_frame("abort9", 9, {16'h02FF, 8'h00}, 0);
    run_frame("wr02",  16, {16'h0266, 8'h00}, 0);

    // Overlong frame; extra byte ignored.
    run_frame("long24", 24, {16'h0477, 8'hFF}, 0);

    // ss_n rising together with the 16th rise still commits.
    run_frame("simul", 16, {16'h0699, 8'h00}, 1);
    run_frame("rd06",  16, {16'h8600, 8'h00}, 0);

    // Reset mid-frame with ss_n held low: nothing happens until ss_n rises.
    s0 = strobe_cnt;
    e0 = err_cnt;
    spi_ss_n = 1'b0;
    wait_clks(4);
    shift_bits(5, {16'h0599, 8'h00}, 0, dummy);
    reset_reset = 1'b1;
    wait_clks(2);
    reset_reset = 1'b0;
    model_reset();
    wait_clks(4);
    #1;
    check("mid_rst_oe", 64'(spi_miso_oe), 64'd0);
    shift_bits(16, {16'h0599, 8'h00}, 0, dummy);
    wait_clks(4);
    spi_ss_n = 1'b1;
    wait_clks(10);
    #1;
    check("mid_rst_regs",   reg_out, model_pack());
    check("mid_rst_strobe", 64'(strobe_cnt - s0), 64'd0);
    check("mid_rst_ferr",   64'(err_cnt - e0), 64'd0);
    check("mid_rst_wraddr", 64'(wr_addr), 64'd0);
    run_frame("post_rst", 16, {16'h0599, 8'h00}, 0);

    // Randomized frames.
    for (int n = 0; n < 40; n++) begin
      logic       rw;
      logic [6:0] addr;
      int         sel, nb;
      rw  = 1'($urandom_range(0, 1));
      sel = $urandom_range(0, 9);
      if (sel < 6)       addr = 7'($urandom_range(0, NUM_REGS - 1));
      else if (sel == 6) addr = 7'h7E;
      else if (sel == 7) addr = 7'h7F;
      else               addr = 7'($urandom_range(0, 127));
      nb = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 24) : 16;
      status_in = 8'($urandom);
      run_frame($sformatf("rnd%0d", n), nb, {rw, addr, 8'($urandom), 8'($urandom)}, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
